// File: rtl/hv_timing_decode_pkg.sv
// kangaroo_video_pkg: shared video count types and default raster timing constants
package kangaroo_video_pkg;
  typedef logic [7:0] hcnt_t;
  typedef logic [8:0] vcnt_t;
  localparam hcnt_t       HBLK_START  = 8'd240;
  localparam hcnt_t       HBLK_END    = 8'd16;
  localparam hcnt_t       HSYNC_START = 8'd248;
  localparam int          HSYNC_LEN   = 8;
  localparam int          VTOTAL      = 264;
  localparam vcnt_t       VBLK_START  = 9'd240;
  localparam vcnt_t       VBLK_END    = 9'd16;
  localparam vcnt_t       VSYNC_START = 9'd248;
  localparam int          VSYNC_LEN   = 4;
  localparam vcnt_t       VLAST       = vcnt_t'(VTOTAL - 1);
  localparam logic [8:0]  HSYNC_STOP  = {1'b0, HSYNC_START} + 9'(HSYNC_LEN);
  localparam logic [9:0]  VSYNC_STOP  = {1'b0, VSYNC_START} + 10'(VSYNC_LEN);
endpackage

// File: rtl/hv_timing_decode_if.sv
// hv_timing_decode_if: raw counter input and decoded timing outputs
interface hv_timing_decode_if;
  import kangaroo_video_pkg::*;
  hcnt_t HC_IN;
  hcnt_t HCNT;
  vcnt_t VCNT;
  logic  HBLANK;
  logic  HSYNC_N;
  logic  VBLANK;
  logic  VSYNC_N;
  logic  LINE_STB;
  logic  FRAME_STB;
  logic  CNT_ERR;
  modport master (output HC_IN, input HCNT, VCNT, HBLANK, HSYNC_N, VBLANK, VSYNC_N, LINE_STB, FRAME_STB, CNT_ERR);
  modport slave  (input HC_IN, output HCNT, VCNT, HBLANK, HSYNC_N, VBLANK, VSYNC_N, LINE_STB, FRAME_STB, CNT_ERR);
endinterface

// File: rtl/hv_timing_decode_hcnt_sync.sv
// hcnt_sync: two-stage sampler of the ripple count, loading only values stable for two samples
module hcnt_sync
  import kangaroo_video_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_N,
  input  hcnt_t hc_i,
  output hcnt_t hcnt_o
);
  hcnt_t s1_q, s2_q, hcnt_q;
  // resample and drop any value that changed between the two stages
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hcnt_q <= '0;
    end else begin
      s1_q <= hc_i;
      s2_q <= s1_q;
      if (s1_q == s2_q) hcnt_q <= s2_q;
    end
  end
  assign hcnt_o = hcnt_q;
endmodule

// File: rtl/hv_timing_decode.sv
// hv_timing_decode: line wrap detect, line counter, H/V decode; HV_TIMING_CHECK_EN builds the count checker
module hv_timing_decode
  import kangaroo_video_pkg::*;
(
  input logic CLK,
  input logic RST_N,
  hv_timing_decode_if.slave bus
);
  hcnt_t hcnt, hprev_q;
  vcnt_t vcnt_q, vcnt_d;
  logic  hblank_q, hsync_n_q, vblank_q, vsync_n_q, line_q, frame_q;
  logic  wrap, vlast;
  hcnt_sync u_sync (.CLK(CLK), .RST_N(RST_N), .hc_i(bus.HC_IN), .hcnt_o(hcnt));
  // only a true FF->00 step ends a line; any other move to 00 is a counter clear
  assign wrap   = (hprev_q == 8'hFF) && (hcnt == 8'h00);
  assign vlast  = vcnt_q == VLAST;
  assign vcnt_d = wrap ? (vlast ? '0 : vcnt_q + 9'd1) : vcnt_q;
  // registered strobes, line counter and decodes of the current counts
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hprev_q   <= '0;
      vcnt_q    <= '0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      hblank_q  <= 1'b1;
      hsync_n_q <= 1'b1;
      vblank_q  <= 1'b1;
      vsync_n_q <= 1'b1;
    end else begin
      hprev_q   <= hcnt;
      vcnt_q    <= vcnt_d;
      line_q    <= wrap;
      frame_q   <= wrap && vlast;
      hblank_q  <= (hcnt >= HBLK_START) || (hcnt < HBLK_END);
      hsync_n_q <= !((hcnt >= HSYNC_START) && ({1'b0, hcnt} < HSYNC_STOP));
      vblank_q  <= (vcnt_d >= VBLK_START) || (vcnt_d < VBLK_END);
      vsync_n_q <= !((vcnt_d >= VSYNC_START) && ({1'b0, vcnt_d} < VSYNC_STOP));
    end
  end
`ifdef HV_TIMING_CHECK_EN
  logic err_q, seen_q;
  // sticky flag on a non-increment step; clears to 00 and the first load after reset are exempt
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q  <= 1'b0;
      seen_q <= 1'b0;
    end else if (hcnt != hprev_q) begin
      seen_q <= 1'b1;
      if (seen_q && hcnt != 8'h00 && hcnt != hprev_q + 8'd1) err_q <= 1'b1;
    end
  end
  assign bus.CNT_ERR = err_q;
`else
  assign bus.CNT_ERR = 1'b0;
`endif
  assign bus.HCNT      = hcnt;
  assign bus.VCNT      = vcnt_q;
  assign bus.HBLANK    = hblank_q;
  assign bus.HSYNC_N   = hsync_n_q;
  assign bus.VBLANK    = vblank_q;
  assign bus.VSYNC_N   = vsync_n_q;
  assign bus.LINE_STB  = line_q;
  assign bus.FRAME_STB = frame_q;
endmodule

// File: tb/tb_hv_timing_decode.sv
// tb_hv_timing_decode: directed self-checking bench for hv_timing_decode
module tb_hv_timing_decode;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0, failures = 0, lcount = 0, fcount = 0, l0, v;
  logic saw00 = 1'b0;
  logic exp_err;
  hv_timing_decode_if bus();
  hv_timing_decode dut (.CLK(clk), .RST_N(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (bus.LINE_STB === 1'b1) lcount++;
      if (bus.FRAME_STB === 1'b1) fcount++;
      if (bus.HCNT === 8'h00) saw00 = 1'b1;
    end
  endtask

  task automatic step(input logic [7:0] val);
    bus.HC_IN = val;
    tick(4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hcnt"}, bus.HCNT, 0);
    chk({tag, "_vcnt"}, bus.VCNT, 0);
    chk({tag, "_hblank"}, bus.HBLANK, 1);
    chk({tag, "_hsync"}, bus.HSYNC_N, 1);
    chk({tag, "_vblank"}, bus.VBLANK, 1);
    chk({tag, "_vsync"}, bus.VSYNC_N, 1);
    chk({tag, "_lstb"}, bus.LINE_STB, 0);
    chk({tag, "_fstb"}, bus.FRAME_STB, 0);
    chk({tag, "_err"}, bus.CNT_ERR, 0);
  endtask

  initial begin
    bus.HC_IN = 8'h37;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset("rst0");
    tick(2);
    rst_n = 1'b1;
    lcount = 0;
    tick(2);
    chk("lat_e1", bus.HCNT, 8'h00);
    tick(1);
    chk("lat_e2", bus.HCNT, 8'h37);
    tick(1);
    chk("t1_hblank", bus.HBLANK, 0);
    chk("t1_lstb", lcount, 0);
    l0 = lcount;
    for (int i = 0; i < 256; i++) begin
      step(8'(i));
      chk("t2_hblank", bus.HBLANK, (i >= 240 || i < 16) ? 1 : 0);
      chk("t2_hsync", bus.HSYNC_N, (i >= 248) ? 0 : 1);
    end
    chk("t2_nostb", lcount, l0);
    chk("t2_vcnt0", bus.VCNT, 0);
    step(8'h00);
    chk("t2_lstb", bus.LINE_STB, 1);
    chk("t2_lcount", lcount, l0 + 1);
    chk("t2_vcnt1", bus.VCNT, 1);
    for (int i = 1; i < 16; i++) step(8'(i));
    l0 = lcount;
    saw00 = 1'b0;
    bus.HC_IN = 8'h00;
    tick(1);
    bus.HC_IN = 8'h10;
    tick(5);
    chk("t3_hcnt", bus.HCNT, 8'h10);
    chk("t3_no00", saw00, 0);
    chk("t3_nostb", lcount, l0);
    chk("t3_vcnt", bus.VCNT, 1);
    chk("t3_err", bus.CNT_ERR, 0);
    fcount = 0;
    for (int i = 1; i <= 264; i++) begin
      step(8'hFF);
      step(8'h00);
      v = (1 + i) % 264;
      chk("t4_vcnt", bus.VCNT, v);
      chk("t4_lstb", bus.LINE_STB, 1);
      chk("t4_vblank", bus.VBLANK, (v >= 240 || v < 16) ? 1 : 0);
      chk("t4_vsync", bus.VSYNC_N, (v >= 248 && v < 252) ? 0 : 1);
      if (v == 0) chk("t4_fstb", bus.FRAME_STB, 1);
    end
    chk("t4_fcount", fcount, 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    step(8'h80);
    chk("t5_h80", bus.HCNT, 8'h80);
    l0 = lcount;
    step(8'h00);
    chk("t5_h00", bus.HCNT, 8'h00);
    chk("t5_nostb", lcount, l0);
    chk("t5_vcnt", bus.VCNT, 0);
    chk("t5_err0", bus.CNT_ERR, 0);
    step(8'h80);
    step(8'h85);
`ifdef HV_TIMING_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    chk("t5_err1", bus.CNT_ERR, exp_err);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(8'hFF);
      step(8'h00);
    end
    chk("t6_vcnt100", bus.VCNT, 100);
    chk("t6_vblank", bus.VBLANK, 0);
    step(8'h40);
    chk("t6_hblank", bus.HBLANK, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("t6_rst");
    tick(1);
    rst_n = 1'b1;
    l0 = lcount;
    step(8'hFF);
    step(8'h00);
    chk("t6_vcnt1", bus.VCNT, 1);
    chk("t6_lcount", lcount, l0 + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
